morse_key_arbiter: RTL

Conditions and arbitrates the two raw Morse key sources (local button, remote FPGA line) into one clean key stream for the pulse interpreter. Synchronizes and debounces each source, grants the channel to one talker at a time with an idle hold-off, and emits a one-cycle talker-change pulse that clears the downstream decode and display stages. It runs in the 1 kHz tick domain and sits directly upstream of `pulse_interpreter`.

---
 rtl/morse_key_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/morse_key_arbiter.sv
// Synchronizes and debounces the local and remote Morse keys, then grants one talker at a time
// with an idle hold-off. Optional KEY_TX_GATE_EN forwards the local key to tx_out only while local owns the channel.
module morse_key_arbiter #(
  parameter int DEBOUNCE_MS = 5,
  parameter int HOLDOFF_MS  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_local,
  input  logic key_remote,
  output logic key_out,
  output logic talker,
  output logic talker_switch,
  output logic busy,
  output logic tx_out
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(HOLDOFF_MS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCAL,
    ST_REMOTE
  } state_t;

  // Channel 0 is the local key, channel 1 the remote key.
  logic [1:0] key_raw;
  logic [1:0] deb_level;

  assign key_raw = {key_remote, key_local};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic          sync1_q;
      logic          sync2_q;
      logic          deb_q;
      logic          deb_d;
      logic [DW-1:0] cnt_q;
      logic [DW-1:0] cnt_d;

      // Counts consecutive disagreeing samples; any agreeing sample restarts the count.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q == DW'(DEBOUNCE_MS - 1)) begin
            deb_d = ~deb_q;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          deb_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= key_raw[gi];
          sync2_q <= sync1_q;
          deb_q   <= deb_d;
          cnt_q   <= cnt_d;
        end
      end

      assign deb_level[gi] = deb_q;
    end
  endgenerate

  logic deb_local;
  logic deb_remote;

  assign deb_local  = deb_level[0];
  assign deb_remote = deb_level[1];

  state_t        state_q, state_d;
  logic [HW-1:0] idle_cnt_q, idle_cnt_d;
  logic          key_out_q, key_out_d;
  logic          talker_q, talker_d;
  logic          switch_q, switch_d;
  logic          busy_q, busy_d;
  logic          owner_key;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    talker_d   = talker_q;
    switch_d   = 1'b0;
    owner_key  = 1'b0;
    key_out_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        // Remote has priority when both keys are down together.
        if (deb_remote) begin
          state_d  = ST_REMOTE;
          talker_d = 1'b0;
          switch_d = talker_q;
        end else if (deb_local) begin
          state_d  = ST_LOCAL;
          talker_d = 1'b1;
          switch_d = ~talker_q;
        end
      end
      ST_LOCAL, ST_REMOTE: begin
        owner_key = (state_q == ST_LOCAL) ? deb_local : deb_remote;
        if (owner_key) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= HW'(HOLDOFF_MS - 1)) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        idle_cnt_d = '0;
      end
    endcase

    case (state_d)
      ST_LOCAL:  key_out_d = deb_local;
      ST_REMOTE: key_out_d = deb_remote;
      default:   key_out_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      key_out_q  <= 1'b0;
      talker_q   <= 1'b0;
      switch_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      key_out_q  <= key_out_d;
      talker_q   <= talker_d;
      switch_q   <= switch_d;
      busy_q     <= busy_d;
    end
  end

`ifdef KEY_TX_GATE_EN
  logic tx_out_q, tx_out_d;

  // Forward the local key only once the upcoming state is a local grant.
  always_comb begin
    tx_out_d = (state_d == ST_LOCAL) & deb_local;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_out_q <= 1'b0;
    end else begin
      tx_out_q <= tx_out_d;
    end
  end

  assign tx_out = tx_out_q;
`else
  assign tx_out = deb_local;
`endif

  assign key_out       = key_out_q;
  assign talker        = talker_q;
  assign talker_switch = switch_q;
  assign busy          = busy_q;

endmodule
